// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave (serial_sub) drives status and results.
interface serial_sub_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         d_bit;
  logic         d_valid;
  logic [W-1:0] diff;
  logic         bout;
  logic         done;

  modport master (
    output start, a, b, bin,
    input  busy, d_bit, d_valid, diff, bout, done
  );

  modport slave (
    input  start, a, b, bin,
    output busy, d_bit, d_valid, diff, bout, done
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor: diff = a - b - bin, LSB first, one full-subtractor cell per clock.
// The request is accepted in IDLE; the result and a one-cycle done pulse follow W cycles later.
module serial_sub #(
  parameter int unsigned W = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int unsigned CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  r_sh_q, r_sh_d;
  logic          borrow_q, borrow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          d_bit_q, d_bit_d;
  logic          d_valid_q, d_valid_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          done_q, done_d;

  // Full-subtractor cell on the current LSBs and the registered borrow
  logic cell_x, cell_y, cell_c, cell_d, cell_b;

  always_comb begin
    cell_x = a_sh_q[0];
    cell_y = b_sh_q[0];
    cell_c = borrow_q;
    cell_d = cell_x ^ cell_y ^ cell_c;
    cell_b = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_c);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    r_sh_d    = r_sh_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    d_bit_d   = d_bit_q;
    d_valid_d = 1'b0;
    diff_d    = diff_q;
    bout_d    = bout_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        r_sh_d    = {cell_d, r_sh_q[W-1:1]};
        borrow_d  = cell_b;
        d_bit_d   = cell_d;
        d_valid_d = 1'b1;
        busy_d    = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          diff_d  = {cell_d, r_sh_q[W-1:1]};
          bout_d  = cell_b;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      r_sh_q    <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      d_bit_q   <= 1'b0;
      d_valid_q <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      r_sh_q    <= r_sh_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      d_bit_q   <= d_bit_d;
      d_valid_q <= d_valid_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.d_bit   = d_bit_q;
  assign bus.d_valid = d_valid_q;
  assign bus.diff    = diff_q;
  assign bus.bout    = bout_q;
  assign bus.done    = done_q;

endmodule
